md_unit: RTL and testbench

MD_UNIT -- requirements
Module: md_unit

---
 rtl/md_unit_pkg.sv | 26 ++
 rtl/md_unit.sv | 118 +++++++++++
 tb/tb_md_unit.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/md_unit_pkg.sv
// Shared pipeline definitions for the multiply/divide unit: operation
// encodings, fixed latencies and the result bundle.
package md_unit_pkg;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } md_op_e;

   localparam int CNT_W = 4;
   localparam logic [CNT_W-1:0] LAT_MULT = 4'd5;
   localparam logic [CNT_W-1:0] LAT_DIV  = 4'd10;

   typedef struct packed {
      logic        valid;
      logic [31:0] hi;
      logic [31:0] lo;
   } md_result_t;

   function automatic logic [CNT_W-1:0] op_latency(md_op_e op);
      return (op == OP_DIV || op == OP_DIVU) ? LAT_DIV : LAT_MULT;
   endfunction

endpackage

// File: rtl/md_unit.sv
// HI/LO multiply/divide unit: fixed-latency behavioural arithmetic on
// operands latched at launch, with mthi/mtlo writes and a Busy flag.
module md_unit
   import md_unit_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        Start,
   input  logic [1:0]  Op,
   input  logic        MtWe,
   input  logic        HiLoSel,
   input  logic        IntReq,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        Busy,
   output logic [31:0] Out
);

   logic [31:0]      hi_reg;
   logic [31:0]      lo_reg;
   logic [31:0]      a_reg;
   logic [31:0]      b_reg;
   md_op_e           op_reg;
   logic [CNT_W-1:0] count_reg;

   logic             launch;
   logic             mt_write;
   logic             commit;
   md_result_t       result;

   logic [63:0]      prod_s;
   logic [63:0]      prod_u;
   logic             div_signed;
   logic             neg_a;
   logic             neg_b;
   logic [31:0]      dvd_mag;
   logic [31:0]      dvs_mag;
   logic [31:0]      dvs_safe;
   logic [31:0]      quo_mag;
   logic [31:0]      rem_mag;

   assign Busy     = (count_reg != '0);
   assign launch   = Start & ~IntReq & ~Busy;
   assign mt_write = MtWe & ~IntReq;
   assign commit   = (count_reg == CNT_W'(1)) & result.valid;

   // Sign-extending to 64 bits lets one plain multiply serve MULT.
   assign prod_s = {{32{a_reg[31]}}, a_reg} * {{32{b_reg[31]}}, b_reg};
   assign prod_u = {32'b0, a_reg} * {32'b0, b_reg};

   // Signed divide runs on magnitudes; the signs are reapplied afterwards,
   // which also yields 0x80000000 / -1 = 0x80000000 rem 0 naturally.
   assign div_signed = (op_reg == OP_DIV);
   assign neg_a      = div_signed & a_reg[31];
   assign neg_b      = div_signed & b_reg[31];
   assign dvd_mag    = neg_a ? -a_reg : a_reg;
   assign dvs_mag    = neg_b ? -b_reg : b_reg;
   assign dvs_safe   = (dvs_mag == '0) ? 32'd1 : dvs_mag;
   assign quo_mag    = dvd_mag / dvs_safe;
   assign rem_mag    = dvd_mag % dvs_safe;

   always_comb begin
      result = '{valid: 1'b1, hi: 32'd0, lo: 32'd0};
      unique case (op_reg)
         OP_MULT: begin
            result.hi = prod_s[63:32];
            result.lo = prod_s[31:0];
         end
         OP_MULTU: begin
            result.hi = prod_u[63:32];
            result.lo = prod_u[31:0];
         end
         OP_DIV, OP_DIVU: begin
            result.valid = (b_reg != '0);
            result.lo    = (neg_a ^ neg_b) ? -quo_mag : quo_mag;
            result.hi    = neg_a ? -rem_mag : rem_mag;
         end
         default: result.valid = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_reg     <= '0;
         b_reg     <= '0;
         op_reg    <= OP_MULT;
         count_reg <= '0;
      end else if (launch) begin
         a_reg     <= A;
         b_reg     <= B;
         op_reg    <= md_op_e'(Op);
         count_reg <= op_latency(md_op_e'(Op));
      end else if (Busy) begin
         count_reg <= count_reg - CNT_W'(1);
      end
   end

   // An mthi/mtlo landing on the commit edge wins for its own register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hi_reg <= '0;
         lo_reg <= '0;
      end else begin
         if (mt_write && HiLoSel)
            hi_reg <= A;
         else if (commit)
            hi_reg <= result.hi;

         if (mt_write && !HiLoSel)
            lo_reg <= A;
         else if (commit)
            lo_reg <= result.lo;
      end
   end

   assign Out = HiLoSel ? hi_reg : lo_reg;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: a cycle-level reference model of HI/LO/Busy
// checked every cycle, plus hand-computed literal expectations.
module tb_md_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        Start = 1'b0;
   logic [1:0]  Op = 2'b00;
   logic        MtWe = 1'b0;
   logic        HiLoSel = 1'b0;
   logic        IntReq = 1'b0;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic        Busy;
   logic [31:0] Out;

   int vectors = 0;
   int miscompares = 0;

   md_unit dut (
      .clk(clk), .reset(reset), .Start(Start), .Op(Op), .MtWe(MtWe),
      .HiLoSel(HiLoSel), .IntReq(IntReq), .A(A), .B(B),
      .Busy(Busy), .Out(Out)
   );

   always #5 clk = ~clk;

   // Reference model: architectural HI/LO, remaining cycles, pending result.
   logic [31:0] m_hi = '0, m_lo = '0, m_rhi = '0, m_rlo = '0;
   int          m_cnt = 0;
   bit          m_rv = 1'b0;

   task automatic compute(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output bit v, output logic [31:0] hi, output logic [31:0] lo);
      int sa, sb;
      longint q, r, p;
      logic [63:0] pv, qv, rv;
      sa = a; sb = b;
      v = 1'b1; hi = '0; lo = '0;
      case (op)
         2'b00: begin p = longint'(sa) * longint'(sb); pv = p; hi = pv[63:32]; lo = pv[31:0]; end
         2'b01: begin pv = 64'(a) * 64'(b); hi = pv[63:32]; lo = pv[31:0]; end
         2'b10: begin
            if (b == 0) v = 1'b0;
            else begin
               q = longint'(sa) / longint'(sb);
               r = longint'(sa) % longint'(sb);
               qv = q; rv = r; lo = qv[31:0]; hi = rv[31:0];
            end
         end
         default: begin
            if (b == 0) v = 1'b0;
            else begin lo = a / b; hi = a % b; end
         end
      endcase
   endtask

   always @(posedge clk or posedge reset) begin : model
      bit launch, mt, cm;
      if (reset) begin
         m_hi = '0; m_lo = '0; m_cnt = 0; m_rv = 1'b0;
      end else begin
         launch = Start && !IntReq && (m_cnt == 0);
         mt     = MtWe && !IntReq;
         cm     = (m_cnt == 1) && m_rv;
         if (cm) begin m_hi = m_rhi; m_lo = m_rlo; end
         if (mt && HiLoSel) m_hi = A;
         if (mt && !HiLoSel) m_lo = A;
         if (m_cnt > 0) m_cnt = m_cnt - 1;
         if (launch) begin
            m_cnt = Op[1] ? 10 : 5;
            compute(Op, A, B, m_rv, m_rhi, m_rlo);
         end
      end
   end

   always @(negedge clk) begin
      vectors++;
      if (Busy !== (m_cnt != 0)) begin
         miscompares++;
         $display("FAIL cycle_busy t=%0t: got %b expected %b", $time, Busy, (m_cnt != 0));
      end
      vectors++;
      if (Out !== (HiLoSel ? m_hi : m_lo)) begin
         miscompares++;
         $display("FAIL cycle_out t=%0t sel=%b: got %h expected %h", $time, HiLoSel, Out,
                  HiLoSel ? m_hi : m_lo);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         $display("ok   %s = %h", name, act);
      end
   endtask

   task automatic peek(input string name, input logic [31:0] ehi, input logic [31:0] elo);
      HiLoSel = 1'b1; #1;
      check({name, "_hi"}, Out, ehi);
      HiLoSel = 1'b0; #1;
      check({name, "_lo"}, Out, elo);
   endtask

   task automatic go(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      @(posedge clk); #2;
      Start = 1'b1; Op = op; A = a; B = b;
      @(posedge clk); #2;
      Start = 1'b0;
   endtask

   task automatic wait_busy(input string name, input int exp);
      int n;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (Busy) n++;
         else break;
      end
      check({name, "_busy_cycles"}, 32'(n), 32'(exp));
   endtask

   initial begin
      #1;
      check("reset_busy", {31'b0, Busy}, 32'd0);
      peek("reset", 32'h0, 32'h0);
      @(posedge clk); #2 reset = 1'b0;

      go(2'b00, 32'hFFFFFFFF, 32'd2);
      wait_busy("mult", 5);
      peek("mult", 32'hFFFFFFFF, 32'hFFFFFFFE);
      check("model_mult_lo", m_lo, 32'hFFFFFFFE);

      go(2'b01, 32'hFFFFFFFF, 32'd2);
      wait_busy("multu", 5);
      peek("multu", 32'h00000001, 32'hFFFFFFFE);

      go(2'b10, 32'hFFFFFFF9, 32'd2);
      wait_busy("div", 10);
      peek("div", 32'hFFFFFFFF, 32'hFFFFFFFD);
      check("model_div_hi", m_hi, 32'hFFFFFFFF);

      // mtlo 0, mthi 0x12345678, then DIVU by zero leaves both alone.
      @(posedge clk); #2; MtWe = 1'b1; HiLoSel = 1'b0; A = 32'h0;
      @(posedge clk); #2; HiLoSel = 1'b1; A = 32'h12345678;
      @(posedge clk); #2; MtWe = 1'b0;
      peek("mt", 32'h12345678, 32'h0);
      go(2'b11, 32'h55, 32'h0);
      wait_busy("divu0", 10);
      peek("divu0", 32'h12345678, 32'h0);

      // IntReq blocks both a launch and an mt write on the same edge.
      @(posedge clk); #2;
      Start = 1'b1; Op = 2'b00; MtWe = 1'b1; HiLoSel = 1'b0; A = 32'hDEAD; B = 32'h3; IntReq = 1'b1;
      @(posedge clk); #2;
      Start = 1'b0; MtWe = 1'b0; IntReq = 1'b0;
      check("intreq_busy", {31'b0, Busy}, 32'd0);
      peek("intreq", 32'h12345678, 32'h0);

      go(2'b10, 32'h80000000, 32'hFFFFFFFF);
      wait_busy("divovf", 10);
      peek("divovf", 32'h0, 32'h80000000);

      // Start while busy is ignored.
      go(2'b11, 32'd100, 32'd7);
      @(posedge clk); #2; Start = 1'b1; Op = 2'b00; A = 32'd5; B = 32'd5;
      @(posedge clk); #2; Start = 1'b0;
      wait_busy("startbusy", 8);
      peek("startbusy", 32'd2, 32'd14);

      // IntReq mid-flight does not cancel.
      go(2'b10, 32'd100, 32'hFFFFFFF9);
      @(posedge clk); #2; IntReq = 1'b1;
      @(posedge clk); #2; IntReq = 1'b0;
      wait_busy("intflight", 8);
      peek("intflight", 32'd2, 32'hFFFFFFF2);

      // mthi on the commit edge wins for HI; LO takes the product.
      go(2'b01, 32'd3, 32'd5);
      repeat (4) @(posedge clk);
      #2; MtWe = 1'b1; HiLoSel = 1'b1; A = 32'hAAAA5555;
      @(posedge clk); #2; MtWe = 1'b0;
      check("mtcommit_busy", {31'b0, Busy}, 32'd0);
      peek("mtcommit", 32'hAAAA5555, 32'd15);

      // Reset during cycle 3 of a DIV: immediate clear, no late commit.
      go(2'b10, 32'd1000, 32'd3);
      @(posedge clk); @(posedge clk); #2;
      reset = 1'b1; #1;
      check("rst_busy", {31'b0, Busy}, 32'd0);
      peek("rst", 32'h0, 32'h0);
      @(posedge clk); #2 reset = 1'b0;
      repeat (12) @(posedge clk);
      #2;
      check("rst_late_busy", {31'b0, Busy}, 32'd0);
      peek("rst_late", 32'h0, 32'h0);

      // Launch on the first edge after reset release.
      reset = 1'b1;
      Start = 1'b1; Op = 2'b00; A = 32'd7; B = 32'hFFFFFFFD;
      @(posedge clk); #2 reset = 1'b0;
      @(posedge clk); #2 Start = 1'b0;
      wait_busy("postrst", 5);
      peek("postrst", 32'hFFFFFFFF, 32'hFFFFFFEB);

      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
